// File: rtl/obi_mem_responder_if.sv
// -----------------------------------------------------------------------------
// obi_mem_responder_if
//
// Bundles the OBI (RI5CY subset) request/response signals between one core
// initiator port (imem_* or dmem_*) and an obi_mem_responder.
// Signal names keep the responder's point of view (_i driven by the
// initiator, _o driven by the responder).
//
// Signals:
//   req_i    request valid               gnt_o    request accepted this cycle
//   addr_i   byte address [31:0]         we_i     1 = write, 0 = read
//   be_i     write byte enables [3:0]    wdata_i  write data [31:0]
//   rvalid_o response valid              rdata_o  read data [31:0]
//   err_o    response error (address out of range)
//
// Modports:
//   master  the initiator side (core or testbench)
//   slave   the responder side
// -----------------------------------------------------------------------------
interface obi_mem_responder_if;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/obi_mem_responder.sv
// -----------------------------------------------------------------------------
// obi_mem_responder
//
// OBI responder backed by a word-addressed on-chip array. One instance sits on
// each core initiator port. Every granted transaction, read or write, returns
// exactly one in-order response RSP_LATENCY cycles after its handshake. Grant
// is throttled by an outstanding-transaction limit and by an optional periodic
// stall so fetch and load/store stall paths can be exercised.
//
// Parameters:
//   DEPTH_WORDS      number of 32-bit words (power of two)
//   BASE_ADDR        byte address mapped to word 0
//   RSP_LATENCY      cycles from handshake to rvalid_o (1..4)
//   MAX_OUTSTANDING  granted-but-unanswered limit (1..RSP_LATENCY)
//   STALL_PERIOD     0 = never stall; N>0 = gnt_o low one cycle in every N
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset (array contents are kept)
//   bus    obi_mem_responder_if.slave (request, grant, response signals)
// -----------------------------------------------------------------------------
module obi_mem_responder #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned RSP_LATENCY     = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STALL_PERIOD    = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    obi_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    localparam logic [31:0]        SPAN_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0]   MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [STALL_W-1:0] STALL_LAST = (STALL_PERIOD > 0) ? STALL_W'(STALL_PERIOD - 1) : '0;

    // Illegal parameter sets are rejected at elaboration.
    if (DEPTH_WORDS < 2 || DEPTH_WORDS > (1 << 28) || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("obi_mem_responder: DEPTH_WORDS must be a power of two in 2..2^28");
    end
    if (RSP_LATENCY < 1 || RSP_LATENCY > 4) begin : g_bad_latency
        $error("obi_mem_responder: RSP_LATENCY must be in 1..4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > RSP_LATENCY) begin : g_bad_outstanding
        $error("obi_mem_responder: MAX_OUTSTANDING must be in 1..RSP_LATENCY");
    end

    logic [31:0]        offset;
    logic               in_range;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        rd_word;

    logic               rsp_valid;
    logic               stall_cycle;
    logic               grant;
    logic               handshake;

    logic [CNT_W-1:0]   outstanding_q, outstanding_d, outstanding_eff;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    logic               pipe_valid_q [RSP_LATENCY];
    logic               pipe_valid_d [RSP_LATENCY];
    logic               pipe_err_q   [RSP_LATENCY];
    logic               pipe_err_d   [RSP_LATENCY];
    logic [31:0]        pipe_data_q  [RSP_LATENCY];
    logic [31:0]        pipe_data_d  [RSP_LATENCY];

    logic [31:0]        mem [DEPTH_WORDS];

    // Address decode. The subtraction wraps for addresses below BASE_ADDR, so
    // the unsigned compare also rejects them.
    always_comb begin
        offset   = bus.addr_i - BASE_ADDR;
        in_range = (offset < SPAN_BYTES);
        word_idx = offset[IDX_W+1:2];
        rd_word  = mem[word_idx];
    end

    // Grant and counter next-state. A response leaving this cycle frees its
    // slot, so a new request can be granted in the same cycle; this lets
    // MAX_OUTSTANDING == RSP_LATENCY sustain one transaction per cycle.
    always_comb begin
        rsp_valid       = pipe_valid_q[RSP_LATENCY-1];
        stall_cycle     = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_LAST);
        outstanding_eff = outstanding_q - CNT_W'(rsp_valid);
        grant           = bus.req_i && !rst_i && (outstanding_eff < MAX_CNT) && !stall_cycle;
        handshake       = grant;

        outstanding_d   = outstanding_q + CNT_W'(handshake) - CNT_W'(rsp_valid);

        if (STALL_PERIOD == 0 || stall_cnt_q == STALL_LAST) begin
            stall_cnt_d = '0;
        end else begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    // Response pipeline next-state. Stage 0 is loaded on the handshake edge;
    // data and error are forced to zero for empty slots, so the outputs are
    // zero whenever rvalid_o is low without any extra gating.
    always_comb begin
        for (int i = 0; i < RSP_LATENCY; i++) begin
            pipe_valid_d[i] = 1'b0;
            pipe_err_d[i]   = 1'b0;
            pipe_data_d[i]  = '0;
        end
        pipe_valid_d[0] = handshake;
        pipe_err_d[0]   = handshake && !in_range;
        pipe_data_d[0]  = (handshake && !bus.we_i && in_range) ? rd_word : 32'h0;
        for (int i = 1; i < RSP_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_err_d[i]   = pipe_err_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            stall_cnt_q   <= '0;
            for (int i = 0; i < RSP_LATENCY; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_err_q[i]   <= 1'b0;
                pipe_data_q[i]  <= '0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            stall_cnt_q   <= stall_cnt_d;
            for (int i = 0; i < RSP_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_d[i];
                pipe_err_q[i]   <= pipe_err_d[i];
                pipe_data_q[i]  <= pipe_data_d[i];
            end
        end
    end

    // The array itself has no reset. Writes never happen while rst_i is high
    // because handshake already includes !rst_i.
    always_ff @(posedge clk_i) begin
        if (handshake && bus.we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign bus.gnt_o    = grant;
    assign bus.rvalid_o = rsp_valid;
    assign bus.rdata_o  = pipe_data_q[RSP_LATENCY-1];
    assign bus.err_o    = pipe_err_q[RSP_LATENCY-1];

    a_rvalid_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i) rsp_valid |-> (outstanding_q != '0));

    a_outstanding_bounded: assert property (
        @(posedge clk_i) disable iff (rst_i) outstanding_q <= MAX_CNT);

endmodule

// File: tb/tb_obi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_obi_mem_responder
//
// Four responders with different parameter sets share one clock:
//   u0  LAT=1 MAX=1 STALL=0 BASE=0      DEPTH=1024  write/read, byte enables
//   u1  LAT=3 MAX=2 STALL=0 BASE=0      DEPTH=1024  pipelining, reset mid-flight
//   u2  LAT=1 MAX=1 STALL=4 BASE=0      DEPTH=1024  grant stall pattern
//   u3  LAT=1 MAX=1 STALL=0 BASE=0x1000 DEPTH=16    out-of-range accesses
// A per-instance reference memory and response queue predict every response.
// -----------------------------------------------------------------------------
module tb_obi_mem_responder;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    localparam int          LAT_T   [4] = '{1, 3, 1, 1};
    localparam logic [31:0] BASE_T  [4] = '{32'h0, 32'h0, 32'h0, 32'h1000};
    localparam int          DEPTH_T [4] = '{1024, 1024, 1024, 16};
    localparam bit          PIPE_GNT [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic r0 = 1'b1, r1 = 1'b1, r2 = 1'b1, r3 = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t        sbq [4][$];
    logic [31:0] mdl [int];

    obi_mem_responder_if b0 ();
    obi_mem_responder_if b1 ();
    obi_mem_responder_if b2 ();
    obi_mem_responder_if b3 ();

    obi_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .RSP_LATENCY(1),
                        .MAX_OUTSTANDING(1), .STALL_PERIOD(0))
        u0 (.clk_i(clk), .rst_i(r0), .bus(b0));
    obi_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .RSP_LATENCY(3),
                        .MAX_OUTSTANDING(2), .STALL_PERIOD(0))
        u1 (.clk_i(clk), .rst_i(r1), .bus(b1));
    obi_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .RSP_LATENCY(1),
                        .MAX_OUTSTANDING(1), .STALL_PERIOD(4))
        u2 (.clk_i(clk), .rst_i(r2), .bus(b2));
    obi_mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .RSP_LATENCY(1),
                        .MAX_OUTSTANDING(1), .STALL_PERIOD(0))
        u3 (.clk_i(clk), .rst_i(r3), .bus(b3));

    // Free-running clock and cycle index used to measure response latency.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case anything above hangs.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard step for one instance, run mid-cycle: pop/compare a
    // response if one is presented, then predict and queue the response for
    // a handshake happening this cycle.
    task automatic monitorStep(input int inst, input virtual obi_mem_responder_if vif, input logic rst);
        exp_t        e;
        logic [31:0] off;
        logic [31:0] w;
        int          key;
        if (rst) begin
            sbq[inst].delete();
            return;
        end
        if (vif.rvalid_o) begin
            if (sbq[inst].size() == 0) begin
                checkOutput($sformatf("u%0d unexpected rvalid", inst), 64'(vif.rvalid_o), 64'd0);
            end else begin
                e = sbq[inst].pop_front();
                checkOutput($sformatf("u%0d rdata", inst), 64'(vif.rdata_o), 64'(e.data));
                checkOutput($sformatf("u%0d err", inst), 64'(vif.err_o), 64'(e.err));
                checkOutput($sformatf("u%0d latency", inst), 64'(cyc - e.cyc), 64'(LAT_T[inst]));
            end
        end
        if (vif.req_i && vif.gnt_o) begin
            off   = vif.addr_i - BASE_T[inst];
            e.cyc = cyc;
            if (off >= 32'(4 * DEPTH_T[inst])) begin
                e.err  = 1'b1;
                e.data = 32'h0;
            end else begin
                key   = inst * (1 << 20) + int'(off >> 2);
                e.err = 1'b0;
                if (vif.we_i) begin
                    w = mdl.exists(key) ? mdl[key] : 32'h0;
                    for (int k = 0; k < 4; k++) begin
                        if (vif.be_i[k]) w[8*k +: 8] = vif.wdata_i[8*k +: 8];
                    end
                    mdl[key] = w;
                    e.data   = 32'h0;
                end else begin
                    e.data = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
                end
            end
            sbq[inst].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        monitorStep(0, b0, r0);
        monitorStep(1, b1, r1);
        monitorStep(2, b2, r2);
        monitorStep(3, b3, r3);
    end

    // One request held until granted (bounded). expWait >= 0 also checks the
    // number of cycles the request waited for its grant.
    task automatic applyStimulus(input virtual obi_mem_responder_if vif, input string tag,
                                 input logic [31:0] addr, input logic we, input logic [3:0] be,
                                 input logic [31:0] wdata, input int expWait);
        int n = 0;
        vif.req_i   = 1'b1;
        vif.addr_i  = addr;
        vif.we_i    = we;
        vif.be_i    = be;
        vif.wdata_i = wdata;
        @(negedge clk);
        while (!vif.gnt_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " granted"}, 64'(vif.gnt_o), 64'd1);
        if (expWait >= 0) checkOutput({tag, " grant wait"}, 64'(n), 64'(expWait));
        @(posedge clk);
        #1;
        vif.req_i   = 1'b0;
        vif.we_i    = 1'b0;
        vif.be_i    = 4'h0;
        vif.wdata_i = 32'h0;
    endtask

    task automatic drainAll();
        int n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 64'd0);
    endtask

    task automatic idleBus(input virtual obi_mem_responder_if vif);
        vif.req_i   = 1'b0;
        vif.addr_i  = 32'h0;
        vif.we_i    = 1'b0;
        vif.be_i    = 4'h0;
        vif.wdata_i = 32'h0;
    endtask

    // Main sequence.
    initial begin
        int idx;
        int c;
        bit hs;
        idleBus(b0);
        idleBus(b1);
        idleBus(b2);
        idleBus(b3);

        // Reset state: no grant even with a request, response bus quiet.
        b0.req_i = 1'b1;
        @(negedge clk);
        checkOutput("reset gnt", 64'(b0.gnt_o), 64'd0);
        checkOutput("reset rvalid", 64'(b0.rvalid_o), 64'd0);
        checkOutput("reset rdata", 64'(b0.rdata_o), 64'd0);
        checkOutput("reset err", 64'(b0.err_o), 64'd0);
        b0.req_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        r0 = 1'b0; r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;

        // Write then read back, one grant per request without waiting.
        applyStimulus(b0, "t1 wr", 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 0);
        applyStimulus(b0, "t1 rd", 32'h10, 1'b0, 4'h0, 32'h0, 0);

        // Byte-enable merge; misaligned read returns the aligned word.
        applyStimulus(b0, "t2 pre", 32'h20, 1'b1, 4'hF, 32'h1122_3344, -1);
        applyStimulus(b0, "t2 be", 32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD, -1);
        applyStimulus(b0, "t2 rd", 32'h20, 1'b0, 4'h0, 32'h0, -1);
        applyStimulus(b0, "t2 rd22", 32'h22, 1'b0, 4'h0, 32'h0, -1);
        // Zero byte enables: response but no update.
        applyStimulus(b0, "t2 pre30", 32'h30, 1'b1, 4'hF, 32'h5566_7788, -1);
        applyStimulus(b0, "t2 be0", 32'h30, 1'b1, 4'h0, 32'hFFFF_FFFF, -1);
        applyStimulus(b0, "t2 rd30", 32'h30, 1'b0, 4'h0, 32'h0, -1);
        drainAll();

        // Pipelining on u1: preload four words, then hold req for 4 reads.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(b1, "t3 pre", 32'h100 + 32'(4 * i), 1'b1, 4'hF, 32'hA000_0000 + 32'(i), -1);
        end
        drainAll();
        idx = 0;
        c   = 0;
        while (idx < 4 && c < 12) begin
            b1.req_i  = 1'b1;
            b1.we_i   = 1'b0;
            b1.addr_i = 32'h100 + 32'(4 * idx);
            @(negedge clk);
            if (c < 5) checkOutput($sformatf("t3 gnt cycle %0d", c), 64'(b1.gnt_o), 64'(PIPE_GNT[c]));
            hs = b1.gnt_o;
            @(posedge clk);
            #1;
            if (hs) idx++;
            c++;
        end
        idleBus(b1);
        checkOutput("t3 reads granted", 64'(idx), 64'd4);
        checkOutput("t3 cycles used", 64'(c), 64'd5);
        drainAll();

        // Stall pattern on u2: fresh reset, then requests every cycle.
        r2 = 1'b1;
        @(posedge clk);
        #1;
        r2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            b2.req_i   = 1'b1;
            b2.we_i    = 1'b1;
            b2.be_i    = 4'hF;
            b2.addr_i  = 32'h40 + 32'(4 * k);
            b2.wdata_i = 32'hC0DE_0000 + 32'(k);
            @(negedge clk);
            checkOutput($sformatf("t4 gnt cycle %0d", k), 64'(b2.gnt_o), 64'((k % 4) != 3));
            @(posedge clk);
            #1;
        end
        idleBus(b2);
        drainAll();

        // Out-of-range accesses on u3.
        applyStimulus(b3, "t5 pre", 32'h1000, 1'b1, 4'hF, 32'hCAFE_F00D, -1);
        applyStimulus(b3, "t5 below", 32'h0FFC, 1'b0, 4'h0, 32'h0, -1);
        applyStimulus(b3, "t5 above", 32'h1040, 1'b1, 4'hF, 32'hFFFF_FFFF, -1);
        applyStimulus(b3, "t5 rd0", 32'h1000, 1'b0, 4'h0, 32'h0, -1);
        applyStimulus(b3, "t5 last", 32'h103C, 1'b1, 4'hF, 32'h0BAD_CAFE, -1);
        applyStimulus(b3, "t5 rdlast", 32'h103C, 1'b0, 4'h0, 32'h0, -1);
        drainAll();

        // Reset mid-flight on u1: the in-flight read must vanish.
        applyStimulus(b1, "t6 rd", 32'h104, 1'b0, 4'h0, 32'h0, 0);
        r1 = 1'b1;
        @(posedge clk);
        #1;
        r1 = 1'b0;
        @(negedge clk);
        checkOutput("t6 outstanding", 64'(u1.outstanding_q), 64'd0);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("t6 rvalid after release %0d", k), 64'(b1.rvalid_o), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        applyStimulus(b1, "t6 new rd", 32'h108, 1'b0, 4'h0, 32'h0, 0);
        drainAll();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
